// File: rtl/sirv_gnrl_xinjector.sv
// Fault injector on a valid/ready stream: after cfg_gap clean beats, XORs cfg_mask into cfg_burst beats.
// Define SIRV_GNRL_XINJ_X_EN (simulation only) to drive masked bits to X instead of inverting them.
module sirv_gnrl_xinjector #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [DW-1:0]    i_dat,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [DW-1:0]    o_dat,
  output logic             o_corrupt,
  input  logic             cfg_arm,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [4:0]       cfg_burst,
  input  logic [DW-1:0]    cfg_mask,
  output logic [1:0]       inj_state,
  output logic [CNT_W-1:0] inj_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_INJECT = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [4:0]       burst_q, burst_d;
  logic [4:0]       rem_q, rem_d;
  logic [DW-1:0]    mask_q, mask_d;
  logic             vld_q, vld_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic             cor_q, cor_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

  logic             accept;
  logic             drain;
  logic             beat_cor;
  logic             inj_clr;
  logic [4:0]       burst_eff;
  logic [DW-1:0]    cor_dat;

  assign i_ready   = ~vld_q | o_ready;
  assign accept    = i_valid & i_ready;
  assign drain     = vld_q & o_ready;
  assign burst_eff = (burst_q == 5'd0) ? 5'd1 : burst_q;

`ifdef SIRV_GNRL_XINJ_X_EN
  assign cor_dat = (i_dat & ~mask_q) | ({DW{1'bx}} & mask_q);
`else
  assign cor_dat = i_dat ^ mask_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    gap_d     = gap_q;
    burst_d   = burst_q;
    rem_d     = rem_q;
    mask_d    = mask_q;
    beat_cor  = 1'b0;
    inj_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_arm) begin
          state_d   = ST_ARMED;
          gap_d     = cfg_gap;
          burst_d   = cfg_burst;
          mask_d    = cfg_mask;
          gap_cnt_d = '0;
          rem_d     = 5'd0;
          inj_clr   = 1'b1;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          if (gap_cnt_q == gap_q) begin
            beat_cor = 1'b1;
            if (burst_eff == 5'd1) begin
              state_d = ST_DONE;
              rem_d   = 5'd0;
            end else begin
              state_d = ST_INJECT;
              rem_d   = burst_eff - 5'd1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_W'(1);
          end
        end
        if (!cfg_arm) state_d = ST_IDLE;
      end
      ST_INJECT: begin
        // rem_q counts corrupted beats still owed, so the last one is taken at rem_q == 1.
        if (accept) begin
          beat_cor = 1'b1;
          rem_d    = (rem_q == 5'd0) ? 5'd0 : rem_q - 5'd1;
          if (rem_q <= 5'd1) state_d = ST_DONE;
        end
        if (!cfg_arm) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (!cfg_arm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d     = vld_q;
    dat_d     = dat_q;
    cor_d     = cor_q;
    inj_cnt_d = inj_cnt_q;
    if (accept) begin
      vld_d = 1'b1;
      dat_d = beat_cor ? cor_dat : i_dat;
      cor_d = beat_cor;
    end else if (drain) begin
      vld_d = 1'b0;
    end
    if (inj_clr) begin
      inj_cnt_d = '0;
    end else if (drain && cor_q && !(&inj_cnt_q)) begin
      inj_cnt_d = inj_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  // NOTE: the data register is reset too, since o_dat must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      gap_q     <= '0;
      burst_q   <= 5'd0;
      rem_q     <= 5'd0;
      mask_q    <= '0;
      vld_q     <= 1'b0;
      dat_q     <= '0;
      cor_q     <= 1'b0;
      inj_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      gap_q     <= gap_d;
      burst_q   <= burst_d;
      rem_q     <= rem_d;
      mask_q    <= mask_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      cor_q     <= cor_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  assign o_valid   = vld_q;
  assign o_dat     = dat_q;
  assign o_corrupt = cor_q;
  assign inj_state = state_q;
  assign inj_cnt   = inj_cnt_q;

endmodule

// File: tb/tb_sirv_gnrl_xinjector.sv
// Self-checking bench for sirv_gnrl_xinjector: directed scenarios plus randomized traffic against a session-level model.
module tb_sirv_gnrl_xinjector;
  localparam int DW    = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic             i_ready;
  logic [DW-1:0]    i_dat;
  logic             o_valid;
  logic             o_ready;
  logic [DW-1:0]    o_dat;
  logic             o_corrupt;
  logic             cfg_arm;
  logic [CNT_W-1:0] cfg_gap;
  logic [4:0]       cfg_burst;
  logic [DW-1:0]    cfg_mask;
  logic [1:0]       inj_state;
  logic [CNT_W-1:0] inj_cnt;

  sirv_gnrl_xinjector #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_dat(i_dat),
    .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat), .o_corrupt(o_corrupt),
    .cfg_arm(cfg_arm), .cfg_gap(cfg_gap), .cfg_burst(cfg_burst), .cfg_mask(cfg_mask),
    .inj_state(inj_state), .inj_cnt(inj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: an arming session counts accepted beats; beat k is corrupted iff gap <= k < gap+burst.
  typedef struct packed {
    logic          c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t       q_m[$];
  beat_t       drained[$];
  bit          on_m;
  int          beats_m, gap_m, blen_m;
  logic [DW-1:0] mask_m;
  int          inj_m;
  localparam int INJ_MAX = (1 << CNT_W) - 1;

  function automatic int exp_state();
    if (!on_m) return 0;
    if (beats_m <= gap_m) return 1;
    if (beats_m < gap_m + blen_m) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    bit    acc, drn;
    beat_t b;
    if (!rst_n) begin
      q_m.delete();
      on_m = 0; beats_m = 0; inj_m = 0;
      return;
    end
    drn = (q_m.size() > 0) && o_ready;
    acc = i_valid && ((q_m.size() == 0) || o_ready);
    b = '0;
    if (acc) begin
      b.c = on_m && (beats_m >= gap_m) && (beats_m < gap_m + blen_m);
      b.d = b.c ? (i_dat ^ mask_m) : i_dat;
    end
    if (!on_m && cfg_arm) inj_m = 0;
    else if (drn && q_m[0].c && inj_m < INJ_MAX) inj_m++;
    if (drn) void'(q_m.pop_front());
    if (acc) q_m.push_back(b);
    if (!on_m) begin
      if (cfg_arm) begin
        on_m    = 1;
        beats_m = 0;
        gap_m   = int'(cfg_gap);
        blen_m  = (cfg_burst == 5'd0) ? 1 : int'(cfg_burst);
        mask_m  = cfg_mask;
      end
    end else begin
      if (acc) beats_m++;
      if (!cfg_arm) on_m = 0;
    end
  endtask

  // One clock: check the combinational ready, advance model and DUT, then check registered outputs.
  task automatic step();
    bit was_rst;
    #1;
    check("i_ready", i_ready, (q_m.size() == 0) || o_ready);
    if (rst_n && o_valid && o_ready) drained.push_back({o_corrupt, o_dat});
    was_rst = !rst_n;
    model_edge();
    @(posedge clk);
    #1;
    check("o_valid", o_valid, q_m.size() > 0);
    if (q_m.size() > 0) begin
      check("o_dat", o_dat, q_m[0].d);
      check("o_corrupt", o_corrupt, q_m[0].c);
    end else if (was_rst) begin
      check("rst_o_dat", o_dat, 0);
      check("rst_o_corrupt", o_corrupt, 0);
    end
    check("inj_state", inj_state, exp_state());
    check("inj_cnt", inj_cnt, inj_m);
  endtask

  task automatic drive(input bit r, input bit a, input bit v, input logic [DW-1:0] d, input bit rdy);
    rst_n = r; cfg_arm = a; i_valid = v; i_dat = d; o_ready = rdy;
    step();
  endtask

  task automatic set_cfg(input int g, input int b, input logic [DW-1:0] m);
    cfg_gap = CNT_W'(g); cfg_burst = 5'(b); cfg_mask = m;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, '0, 1);
    drained.delete();
  endtask

  int n_cor;

  initial begin
    rst_n = 0; cfg_arm = 0; i_valid = 0; i_dat = '0; o_ready = 1;
    set_cfg(0, 0, '0);
    @(posedge clk); @(posedge clk); #1;
    model_edge();
    check("reset_o_valid", o_valid, 0);
    check("reset_o_dat", o_dat, 0);
    check("reset_o_corrupt", o_corrupt, 0);
    check("reset_state", inj_state, 0);
    check("reset_inj_cnt", inj_cnt, 0);
    check("reset_i_ready", i_ready, 1);

    // gap=2, burst=1, low byte mask: third beat corrupted.
    do_reset();
    set_cfg(2, 1, 32'h0000_00FF);
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 32'h1111_1111, 1);
    drive(1, 1, 0, '0, 1);
    check("g2_count", drained.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("g2_beat%0d", i), drained[i],
            (i == 2) ? {1'b1, 32'h1111_11EE} : {1'b0, 32'h1111_1111});
    check("g2_inj_cnt", inj_cnt, 1);
    check("g2_state", inj_state, 3);

    // gap=0, burst=3, full mask.
    do_reset();
    set_cfg(0, 3, 32'hFFFF_FFFF);
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, DW'(i), 1);
    drive(1, 1, 0, '0, 1);
    check("b3_beat0", drained[0], {1'b1, 32'hFFFF_FFFF});
    check("b3_beat1", drained[1], {1'b1, 32'hFFFF_FFFE});
    check("b3_beat2", drained[2], {1'b1, 32'hFFFF_FFFD});
    check("b3_beat3", drained[3], {1'b0, 32'h0000_0003});
    check("b3_inj_cnt", inj_cnt, 3);

    // Backpressure on a held corrupted beat.
    do_reset();
    set_cfg(0, 1, 32'hF0F0_F0F0);
    drive(1, 1, 0, '0, 1);
    drive(1, 1, 1, 32'h1234_5678, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 32'hDEAD_BEEF, 0);
      check("stall_o_dat", o_dat, 32'hE2C4_A688);
      check("stall_o_corrupt", o_corrupt, 1);
      check("stall_i_ready", i_ready, 0);
    end
    drive(1, 1, 0, '0, 1);
    check("stall_inj_cnt", inj_cnt, 1);
    drive(1, 1, 0, '0, 1);
    check("stall_once", drained.size(), 1);

    // Abort after the second corrupted beat.
    do_reset();
    set_cfg(1, 5, 32'hFFFF_0000);
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 32'hA000_0000 + DW'(i), 1);
    drive(1, 0, 0, '0, 1);
    check("abort_state", inj_state, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'hB000_0000 + DW'(i), 1);
    drive(1, 0, 0, '0, 1);
    n_cor = 0;
    foreach (drained[i]) if (drained[i].c) n_cor++;
    check("abort_flagged", n_cor, 2);
    check("abort_total", drained.size(), 6);

    // Reset while a beat is held in INJECT.
    do_reset();
    set_cfg(0, 5, 32'h0000_FFFF);
    drive(1, 1, 0, '0, 1);
    drive(1, 1, 1, 32'h5555_5555, 0);
    drive(1, 1, 0, '0, 0);
    check("pre_rst_state", inj_state, 2);
    check("pre_rst_valid", o_valid, 1);
    drive(0, 1, 0, '0, 0);
    rst_n = 1; cfg_arm = 0; #1;
    check("post_rst_valid", o_valid, 0);
    check("post_rst_inj", inj_cnt, 0);
    check("post_rst_state", inj_state, 0);
    check("post_rst_i_ready", i_ready, 1);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) cfg_arm = ~cfg_arm;
      if ($urandom_range(0, 3) == 0)
        set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom);
      rst_n   = ($urandom_range(0, 99) != 0);
      i_valid = ($urandom_range(0, 9) < 7);
      i_dat   = $urandom;
      o_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
